// File: rtl/step_pulse_gen.sv
// Single-step push-button conditioner: synchroniser, debounce FSM, one-clk step pulse and step counter.
// Optional auto-repeat while the button is held is built only when STEP_AUTOREPEAT_EN is defined.
module step_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4096,
  parameter int unsigned REPEAT_DELAY    = 5000,
  parameter int unsigned REPEAT_PERIOD   = 1250,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             enable,
  input  logic             clr_count,
  output logic             step,
  output logic             pressed,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    DEB_REL   = 3'd4
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("step_pulse_gen: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("step_pulse_gen: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  state_t        state;
  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          cnt_last_c;
  logic          issue_c;

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt;
`endif

  assign cnt_last_c = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // A step is owed whenever the FSM takes an issuing transition this edge.
  always_comb begin
    issue_c = 1'b0;
    case (state)
      DEB_PRESS: issue_c = s2 && cnt_last_c;
`ifdef STEP_AUTOREPEAT_EN
      HELD:      issue_c = s2 && (rpt == RW'(REPEAT_DELAY - 1));
      REPEAT:    issue_c = s2 && (rpt == RW'(REPEAT_PERIOD - 1));
`endif
      default:   issue_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      step       <= 1'b0;
      pressed    <= 1'b0;
      step_count <= '0;
`ifdef STEP_AUTOREPEAT_EN
      rpt        <= '0;
`endif
    end else begin
      s1 <= button;
      s2 <= s1;

      case (state)
        IDLE: begin
          if (s2) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_last_c) begin
            state   <= HELD;
            cnt     <= '0;
            pressed <= 1'b1;
`ifdef STEP_AUTOREPEAT_EN
            rpt     <= '0;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!s2) begin
            state <= DEB_REL;
            cnt   <= '0;
          end
`ifdef STEP_AUTOREPEAT_EN
          else if (rpt == RW'(REPEAT_DELAY - 1)) begin
            state <= REPEAT;
            rpt   <= '0;
          end else begin
            rpt <= rpt + RW'(1);
          end
`endif
        end
`ifdef STEP_AUTOREPEAT_EN
        REPEAT: begin
          if (!s2) begin
            state <= DEB_REL;
            cnt   <= '0;
          end else if (rpt == RW'(REPEAT_PERIOD - 1)) begin
            rpt <= '0;
          end else begin
            rpt <= rpt + RW'(1);
          end
        end
`endif
        DEB_REL: begin
          // A bounce back to 1 returns to HELD and restarts the repeat wait.
          if (s2) begin
            state <= HELD;
            cnt   <= '0;
`ifdef STEP_AUTOREPEAT_EN
            rpt   <= '0;
`endif
          end else if (cnt_last_c) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          pressed <= 1'b0;
        end
      endcase

      step <= issue_c && enable;

      // Clear has priority over a coincident step; the pulse itself still goes out.
      if (clr_count) begin
        step_count <= '0;
      end else if (issue_c && enable) begin
        step_count <= step_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: vector table, hand-written corner sequences and random presses
// checked cycle by cycle against a run-length debounce model.
module tb_step_pulse_gen;

  localparam int D     = 4;
  localparam int RD    = 20;
  localparam int RP    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             button = 1'b0;
  logic             enable = 1'b1;
  logic             clr_count = 1'b0;
  logic             step;
  logic             pressed;
  logic [CNT_W-1:0] step_count;

  int checks = 0;
  int errors = 0;
  int nsteps = 0;

  // Reference model state: synchroniser copy, debounced level, disagreeing-run length.
  bit               m_s1, m_s2, m_p, m_step;
  int               m_run;
  int               m_k;
  logic [CNT_W-1:0] m_count;

  typedef struct {
    logic             button;
    logic             enable;
    logic             clr;
    int               cycles;
    int               exp_steps;
    logic             exp_pressed;
    logic [CNT_W-1:0] exp_count;
  } vec_t;

  vec_t tbl[14];

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .enable    (enable),
    .clr_count (clr_count),
    .step      (step),
    .pressed   (pressed),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_p = 0; m_step = 0;
    m_run = 0; m_k = 0; m_count = '0;
  endtask

  // The debounced level flips once the synchronised input has disagreed with it for D+1 edges.
  task automatic model_edge();
    bit issue;
    issue = 0;
    if (m_s2 != m_p) m_run++;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_p   = m_s2;
      m_run = 0;
      if (m_p) begin
        issue = 1;
        m_k   = 0;
      end
    end else if (m_p) begin
      if (!m_s2) m_k = -1;
      else if (m_k < 0) m_k = 0;
      else begin
        m_k++;
`ifdef STEP_AUTOREPEAT_EN
        if (m_k >= RD && ((m_k - RD) % RP) == 0) issue = 1;
`endif
      end
    end
    m_step = issue && enable;
    if (clr_count) m_count = '0;
    else if (m_step) m_count = m_count + CNT_W'(1);
    m_s2 = m_s1;
    m_s1 = button;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    check("step", 32'(step), 32'(m_step));
    check("pressed", 32'(pressed), 32'(m_p));
    check("step_count", 32'(step_count), 32'(m_count));
    if (step) nsteps++;
  endtask

  task automatic run(input logic b, input int n);
    button = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first;
    int base;
    int len;
    model_reset();

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 10, 1, 1'b1, 16'd1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 16'd1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0,  3, 0, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0,  1, 0, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0,  2, 0, 1'b0, 16'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 10, 0, 1'b1, 16'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 10, 1, 1'b1, 16'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 16'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0,  5, 0, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 10, 1, 1'b0, 16'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b0,  4, 0, 1'b0, 16'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 16'd1};

    // Reset state
    #2;
    check("reset_step", 32'(step), 32'd0);
    check("reset_pressed", 32'(pressed), 32'd0);
    check("reset_count", 32'(step_count), 32'd0);
    tick();
    #3 rst = 1'b1;
    run(1'b0, 3);

    // Vector table
    for (int v = 0; v < 14; v++) begin
      enable    = tbl[v].enable;
      clr_count = tbl[v].clr;
      nsteps    = 0;
      run(tbl[v].button, tbl[v].cycles);
      check($sformatf("vec%0d_steps", v), 32'(nsteps), 32'(tbl[v].exp_steps));
      check($sformatf("vec%0d_pressed", v), 32'(pressed), 32'(tbl[v].exp_pressed));
      check($sformatf("vec%0d_count", v), 32'(step_count), 32'(tbl[v].exp_count));
    end
    enable = 1'b1;
    clr_count = 1'b0;

    // Asynchronous reset in the middle of a held press, then release reset with the button down
    run(1'b1, 8);
    #3 rst = 1'b0;
    #1;
    check("async_rst_step", 32'(step), 32'd0);
    check("async_rst_pressed", 32'(pressed), 32'd0);
    check("async_rst_count", 32'(step_count), 32'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (step && first < 0) first = i;
    end
    check("latency_after_reset", 32'(first), 32'(D + 2));
    run(1'b0, 12);

    // Counter wrap, then clear coincident with a step
    force dut.step_count = 16'hFFFF;
    #1;
    release dut.step_count;
    m_count = 16'hFFFF;
    run(1'b1, 10);
    check("wrap_to_zero", 32'(step_count), 32'd0);
    run(1'b0, 12);
    force dut.step_count = 16'h1234;
    #1;
    release dut.step_count;
    m_count = 16'h1234;
    clr_count = 1'b1;
    nsteps = 0;
    run(1'b1, 10);
    clr_count = 1'b0;
    check("clr_with_step_count", 32'(step_count), 32'd0);
    check("clr_with_step_pulse", 32'(nsteps), 32'd1);
    run(1'b0, 12);

    // Long hold: auto-repeat steps after the accepted press
    base = int'(step_count);
    nsteps = 0;
    run(1'b1, 60);
`ifdef STEP_AUTOREPEAT_EN
    check("hold_steps", 32'(nsteps), 32'd6);
    check("hold_count", 32'(step_count), 32'(base + 6));
`else
    check("hold_steps", 32'(nsteps), 32'd1);
    check("hold_count", 32'(step_count), 32'(base + 1));
`endif
    nsteps = 0;
    run(1'b0, 12);
    check("release_no_step", 32'(nsteps), 32'd0);

    // Random bouncy presses, holds, enable gaps and clears
    for (int seg = 0; seg < 300; seg++) begin
      button = ~button;
      enable = ($urandom % 8) != 0;
      len = ($urandom % 4 == 0) ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        clr_count = ($urandom % 60) == 0;
        tick();
      end
    end
    clr_count = 1'b0;
    enable = 1'b1;
    run(1'b0, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
